mem_responder: RTL
==================

# mem_responder

Word-addressed memory responder on the processor's external bus (EAB address, EDB data). It serves read and write requests issued by the controller's `load_data` / `ctrl_data_out` strobes and stalls the controller with a programmable number of wait states. It signals completion with a one-cycle `mem_ready` pulse. It replaces the zero-latency memory model and is the bus-slave end of the interface the processor drives as initiator.

## Interface
- `ADDR_W`, default 16: address width (EAB).
- `DATA_W`, default 16: data width (EDB).
- `DEPTH`, default 256: number of implemented words. Addresses `>= DEPTH` are out of range.
- `WAIT_CYCLES`, default 2: wait states per access, legal range 0..15.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `EAB`, in, ADDR_W: request address.
- `EDB_in`, in, DATA_W: write data.
- `load_data`, in, 1: write request strobe (level).
- `ctrl_data_out`, in, 1: read request strobe (level).
- `EDB_out`, out, DATA_W: read data. Valid while `EDB_oe` = 1.
- `EDB_oe`, out, 1: drive enable for the top-level EDB tristate.
- `mem_ready`, out, 1: one-cycle completion pulse.
- `bus_err`, out, 1: one-cycle error pulse, coincident with `mem_ready`.

## Operation
- Storage: DEPTH x DATA_W register array. Contents are not cleared by reset.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Samples the strobes every cycle.
  - If exactly one strobe is high, it latches `EAB`, `EDB_in` and the op (read/write) into request registers.
  - Then goes to WAIT if `WAIT_CYCLES` > 0, else to ACCESS.
  - With no strobe high, it stays in IDLE.
- Both strobes high in IDLE is a protocol error:
  - Nothing is latched and no array access occurs.
  - Goes directly to DONE with the error flag set.
- WAIT:
  - A 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Goes to ACCESS when the counter is 0.
- ACCESS (one cycle):
  - If the latched address is `< DEPTH`:
    - Write: commits the latched data to the array at the end of the cycle.
    - Read: loads the array word into the `EDB_out` register.
  - If the latched address is `>= DEPTH`: no array access, the error flag is set, and `EDB_out` is held at 0.
  - Always goes to DONE.
- DONE (one cycle):
  - `mem_ready` = 1.
  - `bus_err` = error flag.
  - `EDB_oe` = 1 only for an error-free read.
  - Always returns to IDLE.
- Strobes and `EAB` / `EDB_in` are ignored in WAIT, ACCESS and DONE. The latched request governs the access.
- Strobes are level-sampled. The initiator must drop its strobe in the DONE cycle. A strobe still high in the IDLE cycle after DONE starts a new access.
- Array index is `EAB[clog2(DEPTH)-1:0]`, used only after the range check.

## Timing
- Request sampled high in IDLE at cycle 0:
  - WAIT occupies cycles 1..W.
  - ACCESS is cycle W+1.
  - DONE / `mem_ready` is cycle W+2.
  - Access latency = `WAIT_CYCLES` + 2 cycles. Minimum is 2 for W = 0.
- Error on both-strobes: `mem_ready` / `bus_err` in cycle 1.
- Back-to-back throughput: one access per W+3 cycles (DONE -> IDLE -> accept).
- Write data is visible to a read issued in the IDLE cycle immediately after DONE.
- Reset (`rst` = 0, asynchronous):
  - State = IDLE, counter = 0, request registers = 0.
  - `EDB_out` = 0, `EDB_oe` = 0, `mem_ready` = 0, `bus_err` = 0.
- Reset mid-access:
  - Asserted before the ACCESS clock edge: the access is aborted and the write is not committed.
  - Asserted after that edge: the write is already committed, and no `mem_ready` is produced.
- Release of reset: the first request is sampled on the first rising edge with `rst` = 1.
- Outputs are registered. No combinational path from inputs to outputs.

## Test plan
- W=2, write `0xBEEF` to `0x0010`. Then read `0x0010`.
  - Write: `mem_ready` exactly 4 cycles after the request, `bus_err` = 0, `EDB_oe` = 0.
  - Read: `mem_ready` after 4 cycles, `EDB_out` = `0xBEEF` with `EDB_oe` = 1 in that cycle only.
- W=0, back-to-back accesses:
  - Write `0x1234` @ `0x0001`, then immediately read `0x0001`.
  - Each access has latency 2, with 3 cycles between accepts.
  - Read returns `0x1234`.
- DEPTH=256, write `0xAAAA` @ `0x0100`:
  - `mem_ready` = `bus_err` = 1 after 4 cycles.
  - A following read @ `0x0000` returns the prior value, unchanged.
  - Read @ `0x0100` returns `bus_err` = 1, `EDB_oe` = 0, `EDB_out` = 0.
- Both strobes high in IDLE:
  - `mem_ready` = `bus_err` = 1 in cycle 1.
  - No array change, verified by reading back the addressed word.
- Write `0x5555` @ `0x0020` (preloaded `0x0F0F`), `rst` pulsed low during WAIT:
  - All outputs go to 0 immediately.
  - A later read @ `0x0020` returns `0x0F0F`.
- Change `EAB` / `EDB_in` and toggle strobes during WAIT:
  - The access completes using the values latched at acceptance.
  - No extra `mem_ready` pulse is produced.

Source files
------------

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Word-addressed bus-slave memory on the external address/data bus. A request
// is accepted in IDLE when exactly one strobe is high. The responder then
// inserts WAIT_CYCLES wait states and performs the array access in ACCESS.
// Completion is reported with a one-cycle mem_ready pulse in DONE.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous active-low reset
//   EAB            : request address
//   EDB_in         : write data
//   load_data      : write request strobe (level)
//   ctrl_data_out  : read request strobe (level)
//   EDB_out        : read data, valid while EDB_oe = 1
//   EDB_oe         : drive enable for the top-level EDB tristate
//   mem_ready      : one-cycle completion pulse
//   bus_err        : one-cycle error pulse, coincident with mem_ready
//
// All outputs come straight from flops. There is no combinational path from
// the inputs to the outputs.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] EAB,
    input  logic [DATA_W-1:0] EDB_in,
    input  logic              load_data,
    input  logic              ctrl_data_out,
    output logic [DATA_W-1:0] EDB_out,
    output logic              EDB_oe,
    output logic              mem_ready,
    output logic              bus_err
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam bit              HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0]      WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // An address is out of range when it is at or above the implemented depth.
    // The compare is one bit wider so that DEPTH = 2**ADDR_W also works.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DEPTH_L);
    endfunction

    // Storage is deliberately left out of reset.
    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    state_t            state_r, state_next_s;
    logic [3:0]        cnt_r, cnt_next_s;
    logic [ADDR_W-1:0] req_addr_r, req_addr_next_s;
    logic [DATA_W-1:0] req_data_r, req_data_next_s;
    logic              req_wr_r, req_wr_next_s;
    logic              err_r, err_next_s;
    logic [DATA_W-1:0] edb_out_r, edb_out_next_s;
    logic              edb_oe_r, edb_oe_next_s;
    logic              mem_ready_r, mem_ready_next_s;
    logic              bus_err_r, bus_err_next_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  idx_s;

    assign idx_s = req_addr_r[IDX_W-1:0];

    // Next-state, request latching and next-output logic for the access FSM.
    // The DONE-cycle outputs are computed on the transition into DONE so that
    // they can be registered and still line up with the DONE cycle.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        req_addr_next_s  = req_addr_r;
        req_data_next_s  = req_data_r;
        req_wr_next_s    = req_wr_r;
        err_next_s       = err_r;
        edb_out_next_s   = edb_out_r;
        edb_oe_next_s    = 1'b0;
        mem_ready_next_s = 1'b0;
        bus_err_next_s   = 1'b0;
        mem_we_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (load_data && ctrl_data_out) begin
                    // Protocol error: the request registers are left untouched.
                    err_next_s       = 1'b1;
                    state_next_s     = ST_DONE;
                    mem_ready_next_s = 1'b1;
                    bus_err_next_s   = 1'b1;
                end else if (load_data || ctrl_data_out) begin
                    req_addr_next_s = EAB;
                    req_data_next_s = EDB_in;
                    req_wr_next_s   = load_data;
                    err_next_s      = 1'b0;
                    if (HAS_WAIT) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_ACCESS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_next_s     = ST_DONE;
                mem_ready_next_s = 1'b1;
                if (out_of_range(req_addr_r)) begin
                    err_next_s     = 1'b1;
                    bus_err_next_s = 1'b1;
                    edb_out_next_s = {DATA_W{1'b0}};
                end else if (req_wr_r) begin
                    err_next_s     = 1'b0;
                    mem_we_s       = 1'b1;
                    edb_out_next_s = {DATA_W{1'b0}};
                end else begin
                    err_next_s     = 1'b0;
                    edb_out_next_s = mem_r[idx_s];
                    edb_oe_next_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, request and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_data_r  <= {DATA_W{1'b0}};
            req_wr_r    <= 1'b0;
            err_r       <= 1'b0;
            edb_out_r   <= {DATA_W{1'b0}};
            edb_oe_r    <= 1'b0;
            mem_ready_r <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            req_addr_r  <= req_addr_next_s;
            req_data_r  <= req_data_next_s;
            req_wr_r    <= req_wr_next_s;
            err_r       <= err_next_s;
            edb_out_r   <= edb_out_next_s;
            edb_oe_r    <= edb_oe_next_s;
            mem_ready_r <= mem_ready_next_s;
            bus_err_r   <= bus_err_next_s;
        end
    end

    // Array write port. Once reset pulls the FSM out of ACCESS, no write
    // enable is raised, so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= req_data_r;
        end
    end

    assign EDB_out   = edb_out_r;
    assign EDB_oe    = edb_oe_r;
    assign mem_ready = mem_ready_r;
    assign bus_err   = bus_err_r;

endmodule
